// File: rtl/mem_stage_pkg.sv
// Shared LC-3b types for the MEM stage: opcode encoding, MEM FSM states,
// byte-enable codes and opcode classification helpers.
package mem_stage_pkg;

    typedef enum logic [3:0] {
        OP_BR   = 4'h0,
        OP_ADD  = 4'h1,
        OP_LDB  = 4'h2,
        OP_STB  = 4'h3,
        OP_JSR  = 4'h4,
        OP_AND  = 4'h5,
        OP_LDR  = 4'h6,
        OP_STR  = 4'h7,
        OP_RTI  = 4'h8,
        OP_NOT  = 4'h9,
        OP_LDI  = 4'ha,
        OP_STI  = 4'hb,
        OP_JMP  = 4'hc,
        OP_SHF  = 4'hd,
        OP_LEA  = 4'he,
        OP_TRAP = 4'hf
    } lc3b_opcode;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_IND  = 2'd1,
        MEM_ACC  = 2'd2
    } lc3b_mem_state;

    localparam logic [1:0] BE_NONE = 2'b00;
    localparam logic [1:0] BE_LOW  = 2'b01;
    localparam logic [1:0] BE_HIGH = 2'b10;
    localparam logic [1:0] BE_WORD = 2'b11;

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LDR) || (op == OP_STR) || (op == OP_LDB) ||
               (op == OP_STB) || (op == OP_LDI) || (op == OP_STI);
    endfunction

    function automatic logic is_store_op(input logic [3:0] op);
        return (op == OP_STR) || (op == OP_STB) || (op == OP_STI);
    endfunction

    function automatic logic is_byte_op(input logic [3:0] op);
        return (op == OP_LDB) || (op == OP_STB);
    endfunction

    function automatic logic is_indirect_op(input logic [3:0] op);
        return (op == OP_LDI) || (op == OP_STI);
    endfunction

endpackage

// File: rtl/mem_access_fsm.sv
// Data-memory access sequencer: pointer read for indirect ops, final access,
// kill tracking for a flush that lands mid-access. Request strobes are
// combinational so an access can issue in the same cycle the op arrives.
module mem_access_fsm
    import mem_stage_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          flush,
    input  logic          indirect,
    input  logic          store,
    input  logic          dmem_resp,
    input  logic [15:0]   dmem_rdata,
    output lc3b_mem_state state,
    output logic [15:0]   ptr,
    output logic          killed,
    output logic          ind_phase,
    output logic          acc_phase,
    output logic          done,
    output logic          dmem_read,
    output logic          dmem_write
);

    // Sequencer state, indirect pointer and kill flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= MEM_IDLE;
            ptr    <= '0;
            killed <= 1'b0;
        end else begin
            case (state)
                MEM_IDLE: begin
                    if (start) begin
                        if (indirect) begin
                            if (dmem_resp) begin
                                ptr   <= dmem_rdata;
                                state <= MEM_ACC;
                            end else begin
                                state <= MEM_IND;
                            end
                        end else if (!dmem_resp) begin
                            state <= MEM_ACC;
                        end
                    end
                end
                MEM_IND: begin
                    if (flush) killed <= 1'b1;
                    if (dmem_resp) begin
                        ptr   <= dmem_rdata;
                        state <= MEM_ACC;
                    end
                end
                MEM_ACC: begin
                    if (dmem_resp) begin
                        state  <= MEM_IDLE;
                        killed <= 1'b0;
                    end else if (flush) begin
                        killed <= 1'b1;
                    end
                end
                default: state <= MEM_IDLE;
            endcase
        end
    end

    // Phase decode and request strobes; IDLE with a fresh op behaves as the first access cycle
    always_comb begin
        ind_phase  = (state == MEM_IND) || ((state == MEM_IDLE) && start && indirect);
        acc_phase  = (state == MEM_ACC) || ((state == MEM_IDLE) && start && !indirect);
        done       = acc_phase && dmem_resp;
        dmem_read  = ind_phase || (acc_phase && !store);
        dmem_write = acc_phase && store;
    end

endmodule

// File: rtl/mem_stage.sv
// LC-3b MEM stage: drives the data-memory port for loads/stores (including
// LDI/STI indirection), stalls the front of the pipe while an access is
// outstanding, and owns the MEM/WB pipeline register.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned INDIRECT_EN = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [3:0]  opcode_in,
    input  logic [15:0] alu_out_in,
    input  logic [15:0] store_data_in,
    input  logic [2:0]  dest_in,
    input  logic        control_flush,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [1:0]  dmem_byte_enable,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata_out,
    output logic        mem_stall,
    output logic        mem_wb_valid,
    output logic [3:0]  mem_wb_opcode,
    output logic [15:0] mem_wb_alu_out,
    output logic [15:0] mem_wb_address,
    output logic [15:0] mem_wb_rdata,
    output logic [2:0]  mem_wb_dest
);

    lc3b_mem_state state;
    logic [15:0]   ptr;
    logic          killed;
    logic          ind_phase;
    logic          acc_phase;
    logic          done;
    logic          mem_op;
    logic          start;
    logic          indirect;
    logic          store;
    logic          byte_op;
    logic [3:0]    op_q;
    logic [15:0]   alu_q;
    logic [15:0]   sd_q;
    logic [3:0]    cur_op;
    logic [15:0]   cur_alu;
    logic [15:0]   cur_sd;
    logic [15:0]   acc_raw;

    // Once an access is in flight the request is driven from the captured op,
    // so a mid-access flush that releases EX/MEM cannot disturb addr/data/be.
    always_comb begin
        mem_op   = valid_in && is_mem_op(opcode_in);
        start    = mem_op && !control_flush && !reset;
        cur_op   = (state == MEM_IDLE) ? opcode_in     : op_q;
        cur_alu  = (state == MEM_IDLE) ? alu_out_in    : alu_q;
        cur_sd   = (state == MEM_IDLE) ? store_data_in : sd_q;
        indirect = (INDIRECT_EN != 0) && is_indirect_op(cur_op);
        store    = is_store_op(cur_op);
        byte_op  = is_byte_op(cur_op);
        acc_raw  = ((state == MEM_ACC) && indirect) ? ptr : cur_alu;
    end

    mem_access_fsm u_fsm (
        .clk        (clk),
        .rst        (reset),
        .start      (start),
        .flush      (control_flush),
        .indirect   (indirect),
        .store      (store),
        .dmem_resp  (dmem_resp),
        .dmem_rdata (dmem_rdata),
        .state      (state),
        .ptr        (ptr),
        .killed     (killed),
        .ind_phase  (ind_phase),
        .acc_phase  (acc_phase),
        .done       (done),
        .dmem_read  (dmem_read),
        .dmem_write (dmem_write)
    );

    // Capture the op that starts an access
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q  <= '0;
            alu_q <= '0;
            sd_q  <= '0;
        end else if ((state == MEM_IDLE) && start) begin
            op_q  <= opcode_in;
            alu_q <= alu_out_in;
            sd_q  <= store_data_in;
        end
    end

    // Address, byte-lane and store-data formatting plus stall
    always_comb begin
        dmem_byte_enable = BE_NONE;
        dmem_addr        = {acc_raw[15:1], 1'b0};
        dmem_wdata_out   = byte_op ? {cur_sd[7:0], cur_sd[7:0]} : cur_sd;
        if (ind_phase) begin
            dmem_addr        = {cur_alu[15:1], 1'b0};
            dmem_byte_enable = BE_WORD;
        end else if (acc_phase) begin
            if (byte_op) begin
                dmem_addr        = acc_raw;
                dmem_byte_enable = acc_raw[0] ? BE_HIGH : BE_LOW;
            end else begin
                dmem_byte_enable = BE_WORD;
            end
        end
        mem_stall = mem_op && !done && !control_flush && !reset;
    end

    // MEM/WB pipeline register; flushed or killed ops become a BR bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_wb_valid   <= 1'b0;
            mem_wb_opcode  <= '0;
            mem_wb_alu_out <= '0;
            mem_wb_address <= '0;
            mem_wb_rdata   <= '0;
            mem_wb_dest    <= '0;
        end else if (!mem_stall) begin
            if (valid_in && !control_flush && !killed) begin
                mem_wb_valid   <= 1'b1;
                mem_wb_opcode  <= opcode_in;
                mem_wb_alu_out <= alu_out_in;
                mem_wb_address <= mem_op ? acc_raw : alu_out_in;
                mem_wb_rdata   <= mem_op ? dmem_rdata : '0;
                mem_wb_dest    <= dest_in;
            end else begin
                mem_wb_valid   <= 1'b0;
                mem_wb_opcode  <= OP_BR;
                mem_wb_alu_out <= '0;
                mem_wb_address <= '0;
                mem_wb_rdata   <= '0;
                mem_wb_dest    <= '0;
            end
        end
    end

endmodule
